// File: rtl/pow2.sv
// ----------------------------------------------------------------------------
// pow2 -- iterative fixed-point base-2 antilog unit
//
// Computes 2^x for x = k + f, where the operand word is {k[7:0], f[23:0]}
// (the same layout the log2 unit produces). The result is unsigned 16.16.
// The fractional part is handled by a shift-and-multiply loop over the bits
// of f, one bit per clock, multiplying a Q2.30 accumulator by
// C[i] = 2^(2^-i). The integer part is then applied as a left shift.
// Any k of 16 or more saturates the result and raises the overflow flag.
// Latency is fixed at 26 edges from accept to the done pulse.
//
// Ports:
//   clk              system clock, rising edge
//   rst              synchronous active-low reset
//   pow2_start       request pulse, only accepted while idle
//   x_in[31:0]       operand {k, f}, latched on accept
//   pow2_result_out  2^x in 16.16, held until the next accept or reset
//   pow2_busy        high from the cycle after accept until the SHIFT edge
//   pow2_done        one-cycle completion pulse
//   pow2_ovf         set when k >= 16, held with the result
//
// Build option:
//   POW2_ROUND_EN    when defined, the iteration products, the final shift and
//                    the C[i] constants use round-to-nearest. Otherwise all
//                    three truncate. Latency is the same in both builds.
// ----------------------------------------------------------------------------
module pow2 #(
    parameter int FRAC_W   = 24,
    parameter int OUT_FRAC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pow2_start,
    input  logic [31:0] x_in,
    output logic [31:0] pow2_result_out,
    output logic        pow2_busy,
    output logic        pow2_done,
    output logic        pow2_ovf
);

    localparam int ITER_W = $clog2(FRAC_W + 1);
    localparam int ROM_D  = 1 << ITER_W;
    localparam int SH     = 30 - OUT_FRAC;

    // ln(2) in Q64, used only when the coefficient table is elaborated
    localparam logic [127:0] LN2_Q64 = 128'hB172_17F7_D1CF_79AB;

    typedef enum logic [1:0] {IDLE, RUN, SHIFT} state_t;

    state_t              state;
    logic [7:0]          k_reg;
    logic [FRAC_W-1:0]   f_sh;
    logic [31:0]         acc;
    logic [ITER_W-1:0]   iter;

    logic [63:0]         product;
    logic [31:0]         acc_mul;
    logic [46:0]         wide;
    logic [31:0]         shifted;

    // Elaboration-time evaluation of 2^(2^-idx) * 2^30 as exp(ln2 * 2^-idx),
    // summed as a Taylor series in Q64 so the final floor/round at 2^-30 is
    // exact for every table entry.
    function automatic logic [31:0] coef(input int idx);
        logic [127:0] y;
        logic [127:0] term;
        logic [127:0] sum;
        y    = LN2_Q64 >> idx;
        term = 128'd1 << 64;
        sum  = term;
        for (int n = 1; n < 24; n++) begin
            term = (term * y) >> 64;
            term = term / 128'(n);
            sum  = sum + term;
        end
`ifdef POW2_ROUND_EN
        sum = sum + (128'd1 << 33);
`endif
        return sum[65:34];
    endfunction

    // Coefficient ROM, indexed directly by the iteration counter; entries
    // outside 1..FRAC_W are never selected during RUN and read as zero.
    logic [31:0] c_rom [0:ROM_D-1];

    for (genvar g = 0; g < ROM_D; g++) begin : g_rom
        localparam logic [31:0] C_VAL = ((g >= 1) && (g <= FRAC_W)) ? coef(g) : 32'd0;
        assign c_rom[g] = C_VAL;
    end

    // Datapath: one accumulator multiply step, and the final integer shift
    // into 16.16. The 47-bit intermediate holds acc << 15 without loss.
    always_comb begin
        product = {32'b0, acc} * {32'b0, c_rom[iter]};
`ifdef POW2_ROUND_EN
        product = product + 64'h0000_0000_2000_0000;
`endif
        acc_mul = 32'(product >> 30);

        wide = {15'b0, acc} << k_reg[3:0];
`ifdef POW2_ROUND_EN
        wide = wide + (47'd1 << (SH - 1));
`endif
        shifted = 32'(wide >> SH);
    end

    // Control FSM. The fraction is held in a shift register so that the bit
    // consumed on iteration i (f[FRAC_W-i]) is always the MSB.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            k_reg           <= '0;
            f_sh            <= '0;
            acc             <= '0;
            iter            <= '0;
            pow2_result_out <= '0;
            pow2_busy       <= 1'b0;
            pow2_done       <= 1'b0;
            pow2_ovf        <= 1'b0;
        end else begin
            pow2_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pow2_start) begin
                        k_reg     <= x_in[31:24];
                        f_sh      <= x_in[FRAC_W-1:0];
                        acc       <= 32'h4000_0000;
                        iter      <= ITER_W'(1);
                        pow2_ovf  <= 1'b0;
                        pow2_busy <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (f_sh[FRAC_W-1]) begin
                        acc <= acc_mul;
                    end
                    f_sh <= f_sh << 1;
                    iter <= iter + 1'b1;
                    if (iter == ITER_W'(FRAC_W)) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (k_reg[7:4] != 4'd0) begin
                        pow2_result_out <= 32'hFFFF_FFFF;
                        pow2_ovf        <= 1'b1;
                    end else begin
                        pow2_result_out <= shifted;
                        pow2_ovf        <= 1'b0;
                    end
                    pow2_busy <= 1'b0;
                    pow2_done <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pow2.sv
// ----------------------------------------------------------------------------
// tb_pow2 -- self-checking bench for the pow2 antilog unit.
// Expected results come from the ideal value 2^(k + f/2^24) * 65536 computed
// with real arithmetic, compared with a tolerance that covers the unit's
// fixed-point rounding; integer exponents and saturation are compared exactly.
// ----------------------------------------------------------------------------
module tb_pow2;

    localparam int DONE_BUDGET = 40;
    localparam int EXP_LAT     = 26;
    localparam int EXP_BUSY    = 25;

    logic        clk;
    logic        rst;
    logic        pow2_start;
    logic [31:0] x_in;
    logic [31:0] pow2_result_out;
    logic        pow2_busy;
    logic        pow2_done;
    logic        pow2_ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] x;
        logic [31:0] exp_res;
        int          tol;
        logic        exp_ovf;
        logic        has_prev;
        logic [31:0] prev_res;
    } vec_t;

    typedef struct {
        int          lat;
        int          busy_cyc;
        logic [31:0] res_acc;
        logic        ovf_acc;
        logic        busy_done;
        logic [31:0] res;
        logic        ovf;
    } op_t;

    vec_t vecs[$];

    pow2 dut (
        .clk             (clk),
        .rst             (rst),
        .pow2_start      (pow2_start),
        .x_in            (x_in),
        .pow2_result_out (pow2_result_out),
        .pow2_busy       (pow2_busy),
        .pow2_done       (pow2_done),
        .pow2_ovf        (pow2_ovf)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare within a tolerance and count the outcome
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input longint exp_val, input int tol);
        longint a;
        longint diff;
        a    = longint'(act);
        diff = (a > exp_val) ? (a - exp_val) : (exp_val - a);
        checks++;
        if (diff > longint'(tol)) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (tol %0d)",
                     name, act, exp_val[31:0], tol);
        end
    endtask

    // Ideal reference: 2^x in 16.16 with a tolerance for fixed-point error
    function automatic void refModel(input logic [31:0] x, output longint exp_res,
                                     output int tol, output logic exp_ovf);
        real ideal;
        if (x[31:24] >= 8'd16) begin
            exp_res = 64'h0000_0000_FFFF_FFFF;
            tol     = 0;
            exp_ovf = 1'b1;
        end else begin
            ideal   = $pow(2.0, real'(x[31:24]) + real'(x[23:0]) / 16777216.0) * 65536.0;
            exp_res = longint'($floor(ideal));
            tol     = int'(exp_res >>> 22) + 2;
            exp_ovf = 1'b0;
        end
    endfunction

    // Wait for done, sampling on falling edges; lat counts cycles after accept
    task automatic waitDone(output op_t r);
        r.lat       = 0;
        r.busy_cyc  = 0;
        r.res_acc   = '0;
        r.ovf_acc   = 1'b0;
        r.busy_done = 1'b0;
        while (r.lat < DONE_BUDGET) begin
            @(negedge clk);
            r.lat++;
            if (r.lat == 1) begin
                r.res_acc = pow2_result_out;
                r.ovf_acc = pow2_ovf;
            end
            if (pow2_busy) r.busy_cyc++;
            if (pow2_done) begin
                r.busy_done = pow2_busy;
                break;
            end
        end
        r.res = pow2_result_out;
        r.ovf = pow2_ovf;
    endtask

    // Caller is in the low clock phase; start is accepted at the next edge
    task automatic applyStimulus(input logic [31:0] x, output op_t r);
        pow2_start = 1'b1;
        x_in       = x;
        @(posedge clk);
        #1;
        pow2_start = 1'b0;
        x_in       = $urandom;
        waitDone(r);
    endtask

    task automatic addVec(input string n, input logic [31:0] x, input logic [31:0] e,
                          input int tol, input logic ovf, input logic hp,
                          input logic [31:0] pr);
        vec_t v;
        v.name = n; v.x = x; v.exp_res = e; v.tol = tol; v.exp_ovf = ovf;
        v.has_prev = hp; v.prev_res = pr;
        vecs.push_back(v);
    endtask

    initial begin
        op_t         r;
        op_t         r2;
        longint      e_res;
        int          e_tol;
        logic        e_ovf;
        logic [31:0] x;
        real         lg;
        int          kk;
        longint      ff;
        int          extra_done;

        rst        = 1'b0;
        pow2_start = 1'b0;
        x_in       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        checkOutput("reset_result", pow2_result_out, 0, 0);
        checkOutput("reset_busy",   {31'b0, pow2_busy}, 0, 0);
        checkOutput("reset_done",   {31'b0, pow2_done}, 0, 0);
        checkOutput("reset_ovf",    {31'b0, pow2_ovf},  0, 0);

        addVec("zero",      32'h0000_0000, 32'h0001_0000, 0, 1'b0, 1'b1, 32'h0000_0000);
        addVec("k3",        32'h0300_0000, 32'h0008_0000, 0, 1'b0, 1'b1, 32'h0001_0000);
        addVec("k15",       32'h0F00_0000, 32'h8000_0000, 0, 1'b0, 1'b1, 32'h0008_0000);
        addVec("half",      32'h0080_0000, 32'h0001_6A09, 1, 1'b0, 1'b1, 32'h8000_0000);
        addVec("one75",     32'h01C0_0000, 32'h0003_5D13, 1, 1'b0, 1'b0, 32'h0);
        addVec("k16",       32'h1000_0000, 32'hFFFF_FFFF, 0, 1'b1, 1'b0, 32'h0);
        addVec("zero_post", 32'h0000_0000, 32'h0001_0000, 0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        addVec("kmax",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 1'b1, 32'h0001_0000);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].x, r);
            checkOutput({vecs[i].name, "_latency"}, 32'(r.lat), EXP_LAT, 0);
            checkOutput({vecs[i].name, "_busy_cycles"}, 32'(r.busy_cyc), EXP_BUSY, 0);
            checkOutput({vecs[i].name, "_busy_at_done"}, {31'b0, r.busy_done}, 0, 0);
            checkOutput({vecs[i].name, "_ovf_at_accept"}, {31'b0, r.ovf_acc}, 0, 0);
            if (vecs[i].has_prev)
                checkOutput({vecs[i].name, "_held_at_accept"}, r.res_acc,
                            longint'(vecs[i].prev_res), 0);
            checkOutput({vecs[i].name, "_result"}, r.res, longint'(vecs[i].exp_res), vecs[i].tol);
            checkOutput({vecs[i].name, "_ovf"}, {31'b0, r.ovf}, longint'(vecs[i].exp_ovf), 0);
            repeat (2) @(negedge clk);
        end

        // Saturated result and flag stay put while idle
        repeat (5) @(negedge clk);
        checkOutput("sat_hold_result", pow2_result_out, 64'h0000_0000_FFFF_FFFF, 0);
        checkOutput("sat_hold_ovf", {31'b0, pow2_ovf}, 1, 0);
        checkOutput("sat_hold_done", {31'b0, pow2_done}, 0, 0);

        // Back-to-back: a new start in the done cycle is a fresh accept
        applyStimulus(32'h0100_0000, r);
        checkOutput("b2b_first_result", r.res, 64'h0002_0000, 0);
        applyStimulus(32'h0500_0000, r2);
        checkOutput("b2b_second_latency", 32'(r2.lat), EXP_LAT, 0);
        checkOutput("b2b_held_at_accept", r2.res_acc, 64'h0002_0000, 0);
        checkOutput("b2b_second_result", r2.res, 64'h0020_0000, 0);
        repeat (2) @(negedge clk);

        // A start pulse during RUN is ignored and not queued
        pow2_start = 1'b1;
        x_in       = 32'h0200_0000;
        @(posedge clk);
        #1;
        pow2_start = 1'b0;
        x_in       = 32'h0F80_0000;
        r.lat = 0;
        while (r.lat < DONE_BUDGET) begin
            @(negedge clk);
            r.lat++;
            if (r.lat == 5) pow2_start = 1'b1;
            if (r.lat == 7) pow2_start = 1'b0;
            if (pow2_done) break;
        end
        checkOutput("busy_start_latency", 32'(r.lat), EXP_LAT, 0);
        checkOutput("busy_start_result", pow2_result_out, 64'h0004_0000, 0);
        checkOutput("busy_start_ovf", {31'b0, pow2_ovf}, 0, 0);
        extra_done = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (pow2_done) extra_done++;
        end
        checkOutput("busy_start_not_queued", 32'(extra_done), 0, 0);

        // Round trip with the log2 unit's truncated output for 10 and 999
        lg = $ln(10.0) / $ln(2.0);
        kk = int'($floor(lg));
        ff = longint'($floor((lg - real'(kk)) * 16777216.0));
        x  = {kk[7:0], ff[23:0]};
        applyStimulus(x, r);
        checkOutput("roundtrip_10", r.res, 64'h000A_0000, 4);
        lg = $ln(999.0) / $ln(2.0);
        kk = int'($floor(lg));
        ff = longint'($floor((lg - real'(kk)) * 16777216.0));
        x  = {kk[7:0], ff[23:0]};
        applyStimulus(x, r);
        checkOutput("roundtrip_999", r.res, 64'h03E7_0000, 4);
        @(negedge clk);

        // Randomized operands against the ideal model
        for (int n = 0; n < 30; n++) begin
            x = {8'($urandom_range(0, 17)), 24'($urandom)};
            refModel(x, e_res, e_tol, e_ovf);
            applyStimulus(x, r);
            checkOutput($sformatf("rand%0d_result_x%08h", n, x), r.res, e_res, e_tol);
            checkOutput($sformatf("rand%0d_ovf", n), {31'b0, r.ovf}, longint'(e_ovf), 0);
            checkOutput($sformatf("rand%0d_latency", n), 32'(r.lat), EXP_LAT, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of an operation discards it
        applyStimulus(32'h0300_0000, r);
        @(negedge clk);
        pow2_start = 1'b1;
        x_in       = 32'h0180_0000;
        @(posedge clk);
        #1;
        pow2_start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset_busy",   {31'b0, pow2_busy}, 0, 0);
        checkOutput("midreset_done",   {31'b0, pow2_done}, 0, 0);
        checkOutput("midreset_result", pow2_result_out, 0, 0);
        rst = 1'b1;
        extra_done = 0;
        for (int c = 0; c < DONE_BUDGET; c++) begin
            @(negedge clk);
            if (pow2_done) extra_done++;
        end
        checkOutput("midreset_no_done", 32'(extra_done), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
